logic_op_sequencer: RTL and testbench

- Command-level controller that sequences the 8x32-bit matrix logical unit.
- Accepts one opcode and constant per operation, then streams operand rows in (8 rows for A, plus 8 for B on two-operand ops), drives the unit's one-hot operation select and lines count, and waits for its ready flag.
- Captures the 256-bit result and streams it back out as 8 rows.
- Sits between the instruction/command front end and the logical unit; it is the only driver of the unit's inputs.

---
 rtl/logic_op_sequencer_if.sv | 38 +++
 rtl/logic_op_sequencer.sv | 130 +++++++++++++
 tb/tb_logic_op_sequencer.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/logic_op_sequencer_if.sv
// logic_op_sequencer_if: command, row stream, status and logical-unit signals of the sequencer
interface logic_op_sequencer_if #(
    parameter int CNT_W = 8
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [2:0]       cmd_op;
    logic [31:0]      cmd_const;
    logic             row_in_valid;
    logic             row_in_ready;
    logic [31:0]      row_in_data;
    logic             row_out_valid;
    logic             row_out_ready;
    logic [31:0]      row_out_data;
    logic             row_out_last;
    logic             busy;
    logic             err_timeout;
    logic             lu_clear;
    logic [CNT_W-1:0] lu_lines_count;
    logic [255:0]     lu_matrix_a;
    logic [255:0]     lu_matrix_b;
    logic [31:0]      lu_constant;
    logic [7:0]       lu_op_sel;
    logic             lu_ready;
    logic [255:0]     lu_result;

    modport slave (
        input  cmd_valid, cmd_op, cmd_const, row_in_valid, row_in_data, row_out_ready, lu_ready, lu_result,
        output cmd_ready, row_in_ready, row_out_valid, row_out_data, row_out_last, busy, err_timeout,
               lu_clear, lu_lines_count, lu_matrix_a, lu_matrix_b, lu_constant, lu_op_sel
    );

    modport master (
        output cmd_valid, cmd_op, cmd_const, row_in_valid, row_in_data, row_out_ready, lu_ready, lu_result,
        input  cmd_ready, row_in_ready, row_out_valid, row_out_data, row_out_last, busy, err_timeout,
               lu_clear, lu_lines_count, lu_matrix_a, lu_matrix_b, lu_constant, lu_op_sel
    );
endinterface

// File: rtl/logic_op_sequencer.sv
// logic_op_sequencer: loads operand rows, runs the 8x32 matrix logical unit and drains its result as rows
module logic_op_sequencer #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W = 8
) (
    input logic                clk,
    input logic                reset,
    logic_op_sequencer_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] LOAD_A = 3'd1;
    localparam logic [2:0] LOAD_B = 3'd2;
    localparam logic [2:0] EXEC   = 3'd3;
    localparam logic [2:0] DRAIN  = 3'd4;
    localparam logic [2:0] CLEAR  = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      const_q, const_d;
    logic [255:0]     a_q, a_d, b_q, b_d, res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, tmo_q, tmo_d;
    logic [2:0]       r_q, r_d;
    logic             err_q, err_d, clr_q, clr_d;
    logic             cmd_fire, in_fire, out_fire, two_op;

    assign cmd_fire           = bus.cmd_valid && bus.cmd_ready;
    assign in_fire            = bus.row_in_valid && bus.row_in_ready;
    assign out_fire           = bus.row_out_valid && bus.row_out_ready;
    assign two_op             = (op_q == 3'd5) || (op_q == 3'd7);
    assign bus.cmd_ready      = state_q == IDLE;
    assign bus.busy           = state_q != IDLE;
    assign bus.row_in_ready   = (state_q == LOAD_A) || (state_q == LOAD_B);
    assign bus.row_out_valid  = state_q == DRAIN;
    assign bus.row_out_last   = (state_q == DRAIN) && (r_q == 3'd7);
    assign bus.row_out_data   = res_q[{~r_q, 5'd0} +: 32];
    assign bus.err_timeout    = err_q;
    assign bus.lu_clear       = clr_q || (state_q == CLEAR);
    assign bus.lu_lines_count = cnt_q;
    assign bus.lu_matrix_a    = a_q;
    assign bus.lu_matrix_b    = b_q;
    assign bus.lu_constant    = const_q;
    assign bus.lu_op_sel      = (state_q == EXEC) ? (8'b1 << op_q) : 8'b0;

    // Next-state and datapath updates; row k lives at bits [(7-k)*32 +: 32], i.e. row 0 at the top
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        const_d = const_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        r_d     = r_q;
        err_d   = err_q;
        clr_d   = 1'b0;
        case (state_q)
            IDLE: if (cmd_fire) begin
                op_d    = bus.cmd_op;
                const_d = bus.cmd_const;
                a_d     = '0;
                b_d     = '0;
                cnt_d   = '0;
                err_d   = 1'b0;
                clr_d   = 1'b1;
                state_d = LOAD_A;
            end
            LOAD_A: if (in_fire) begin
                a_d[{~cnt_q[2:0], 5'd0} +: 32] = bus.row_in_data;
                cnt_d = cnt_q + CNT_W'(1);
                tmo_d = '0;
                if (cnt_q == CNT_W'(7)) state_d = two_op ? LOAD_B : EXEC;
            end
            LOAD_B: if (in_fire) begin
                b_d[{~cnt_q[2:0], 5'd0} +: 32] = bus.row_in_data;
                cnt_d = cnt_q + CNT_W'(1);
                tmo_d = '0;
                if (cnt_q == CNT_W'(15)) state_d = EXEC;
            end
            EXEC: if (bus.lu_ready) begin
                res_d   = bus.lu_result;
                r_d     = 3'd0;
                state_d = DRAIN;
            end else if (tmo_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                err_d   = 1'b1;
                state_d = CLEAR;
            end else begin
                tmo_d = tmo_q + CNT_W'(1);
            end
            DRAIN: if (out_fire) begin
                r_d = r_q + 3'd1;
                if (r_q == 3'd7) state_d = CLEAR;
            end
            CLEAR: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers with asynchronous abort to an all-zero IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            op_q    <= '0;
            const_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            r_q     <= '0;
            err_q   <= 1'b0;
            clr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            const_q <= const_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            r_q     <= r_d;
            err_q   <= err_d;
            clr_q   <= clr_d;
        end
    end
endmodule

// File: tb/tb_logic_op_sequencer.sv
// tb_logic_op_sequencer: randomized scenarios against a behavioural model of the sequencer and logical unit
module tb_logic_op_sequencer;
    localparam int TMO = 64;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic_op_sequencer_if bus();
    logic_op_sequencer dut (.clk(clk), .reset(reset), .bus(bus));

    int n_checks = 0;
    int n_fail = 0;
    logic [31:0] ra[8], rb[8], got[8];
    logic [2:0]  next_op;
    logic [31:0] next_const;
    bit hold_cmd = 0;
    bit stall = 0;

    function automatic logic [31:0] model_row(input logic [2:0] op, input int k, input logic [31:0] c);
        case (op)
            3'd0: return ra[(k + 1) % 8];
            3'd1: return ra[(k + 7) % 8];
            3'd2: return ra[k] >> 1;
            3'd3: return ra[k] << 1;
            3'd4: return ra[k] & c;
            3'd5: return ra[k] & rb[k];
            3'd6: return ra[k] ^ c;
            default: return ra[k] | rb[k];
        endcase
    endfunction

    task automatic randomize_rows();
        for (int k = 0; k < 8; k++) begin
            ra[k] = $urandom;
            rb[k] = $urandom;
        end
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] c, input int delay, input bit pre);
        int n, idx, cyc;
        bit two;
        logic [31:0] e[8];
        logic [255:0] pa, pb;
        two = (op == 3'd5) || (op == 3'd7);
        n = two ? 16 : 8;
        for (int k = 0; k < 8; k++) e[k] = model_row(op, k, c);
        pa = {ra[0], ra[1], ra[2], ra[3], ra[4], ra[5], ra[6], ra[7]};
        pb = two ? {rb[0], rb[1], rb[2], rb[3], rb[4], rb[5], rb[6], rb[7]} : 256'd0;
        if (!pre) begin
            cyc = 0;
            while (bus.cmd_ready !== 1'b1 && cyc < 200) begin @(negedge clk); cyc++; end
            n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL cmd_ready_wait: got %b need 1", bus.cmd_ready); end
            bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_const = c;
        end
        @(negedge clk);
        bus.cmd_valid = hold_cmd;
        if (hold_cmd) begin bus.cmd_op = next_op; bus.cmd_const = next_const; end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL accept_busy: got %b need 1", bus.busy); end
        n_checks++; if (bus.lu_clear !== 1'b1) begin n_fail++; $display("FAIL accept_clear: got %b need 1", bus.lu_clear); end
        n_checks++; if (bus.err_timeout !== 1'b0) begin n_fail++; $display("FAIL accept_err: got %b need 0", bus.err_timeout); end
        n_checks++; if (bus.lu_constant !== c) begin n_fail++; $display("FAIL accept_const: got %h need %h", bus.lu_constant, c); end
        n_checks++; if (bus.lu_matrix_a !== 256'd0) begin n_fail++; $display("FAIL accept_a_clr: got %h need 0", bus.lu_matrix_a); end
        n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL accept_cmd_ready: got %b need 0", bus.cmd_ready); end
        idx = 0; cyc = 0;
        while (idx < n && cyc < 400) begin
            bus.row_in_valid = ($urandom_range(0, 3) != 0);
            bus.row_in_data = (idx < 8) ? ra[idx % 8] : rb[idx % 8];
            n_checks++; if (bus.row_in_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready: got %b need 1", bus.row_in_ready); end
            n_checks++; if (bus.lu_lines_count !== 8'(idx)) begin n_fail++; $display("FAIL load_count: got %0d need %0d", bus.lu_lines_count, idx); end
            n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL load_cmd_ready: got %b need 0", bus.cmd_ready); end
            if (cyc > 0) begin
                n_checks++; if (bus.lu_clear !== 1'b0) begin n_fail++; $display("FAIL load_clear: got %b need 0", bus.lu_clear); end
            end
            @(negedge clk);
            if (bus.row_in_valid) idx++;
            cyc++;
        end
        n_checks++; if (idx != n) begin n_fail++; $display("FAIL load_bound: got %0d rows need %0d", idx, n); end
        bus.row_in_valid = 1'b1; bus.row_in_data = $urandom;
        bus.lu_result = {e[0], e[1], e[2], e[3], e[4], e[5], e[6], e[7]};
        n_checks++; if (bus.row_in_ready !== 1'b0) begin n_fail++; $display("FAIL exec_row_ready: got %b need 0", bus.row_in_ready); end
        n_checks++; if (bus.lu_lines_count !== 8'(n)) begin n_fail++; $display("FAIL exec_count: got %0d need %0d", bus.lu_lines_count, n); end
        n_checks++; if (bus.lu_matrix_a !== pa) begin n_fail++; $display("FAIL matrix_a: got %h need %h", bus.lu_matrix_a, pa); end
        n_checks++; if (bus.lu_matrix_b !== pb) begin n_fail++; $display("FAIL matrix_b: got %h need %h", bus.lu_matrix_b, pb); end
        n_checks++; if (bus.row_out_valid !== 1'b0) begin n_fail++; $display("FAIL exec_out_valid: got %b need 0", bus.row_out_valid); end
        if (delay < 0) begin
            cyc = 0;
            while (bus.lu_op_sel !== 8'h00 && cyc < 200) begin
                n_checks++; if (bus.row_out_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_out_valid: got %b need 0", bus.row_out_valid); end
                @(negedge clk);
                bus.row_in_valid = 1'b0;
                cyc++;
            end
            n_checks++; if (cyc != TMO) begin n_fail++; $display("FAIL tmo_cycles: got %0d need %0d", cyc, TMO); end
            n_checks++; if (bus.err_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b need 1", bus.err_timeout); end
            n_checks++; if (bus.lu_clear !== 1'b1) begin n_fail++; $display("FAIL tmo_clear: got %b need 1", bus.lu_clear); end
            n_checks++; if (bus.row_out_valid !== 1'b0) begin n_fail++; $display("FAIL tmo_no_out: got %b need 0", bus.row_out_valid); end
            @(negedge clk);
            n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL tmo_idle: got %b need 1", bus.cmd_ready); end
            n_checks++; if (bus.err_timeout !== 1'b1) begin n_fail++; $display("FAIL tmo_sticky: got %b need 1", bus.err_timeout); end
            n_checks++; if (bus.lu_lines_count !== 8'd0) begin n_fail++; $display("FAIL tmo_count: got %0d need 0", bus.lu_lines_count); end
            return;
        end
        for (int i = 0; i < delay; i++) begin
            n_checks++; if (bus.lu_op_sel !== (8'b1 << op)) begin n_fail++; $display("FAIL exec_sel: got %h need %h", bus.lu_op_sel, 8'b1 << op); end
            @(negedge clk);
            bus.row_in_valid = 1'b0;
        end
        bus.lu_ready = 1'b1;
        n_checks++; if (bus.lu_op_sel !== (8'b1 << op)) begin n_fail++; $display("FAIL exec_sel_rdy: got %h need %h", bus.lu_op_sel, 8'b1 << op); end
        @(negedge clk);
        bus.lu_ready = 1'b0; bus.row_in_valid = 1'b0; bus.lu_result = '0;
        n_checks++; if (bus.lu_op_sel !== 8'h00) begin n_fail++; $display("FAIL drain_sel: got %h need 00", bus.lu_op_sel); end
        idx = 0; cyc = 0;
        while (idx < 8 && cyc < 200) begin
            bus.row_out_ready = stall ? (cyc % 4 == 0 || cyc % 4 == 3) : 1'b1;
            n_checks++; if (bus.row_out_valid !== 1'b1) begin n_fail++; $display("FAIL drain_valid: got %b need 1", bus.row_out_valid); end
            n_checks++; if (bus.row_out_data !== e[idx]) begin n_fail++; $display("FAIL drain_data[%0d]: got %h need %h", idx, bus.row_out_data, e[idx]); end
            n_checks++; if (bus.row_out_last !== (idx == 7)) begin n_fail++; $display("FAIL drain_last[%0d]: got %b need %b", idx, bus.row_out_last, idx == 7); end
            if (bus.row_out_ready) got[idx] = bus.row_out_data;
            @(negedge clk);
            if (bus.row_out_ready) idx++;
            cyc++;
        end
        bus.row_out_ready = 1'b0;
        n_checks++; if (idx != 8) begin n_fail++; $display("FAIL drain_bound: got %0d rows need 8", idx); end
        n_checks++; if (bus.row_out_valid !== 1'b0) begin n_fail++; $display("FAIL clear_valid: got %b need 0", bus.row_out_valid); end
        n_checks++; if (bus.lu_clear !== 1'b1) begin n_fail++; $display("FAIL clear_pulse: got %b need 1", bus.lu_clear); end
        n_checks++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL clear_busy: got %b need 1", bus.busy); end
        @(negedge clk);
        n_checks++; if (bus.lu_clear !== 1'b0) begin n_fail++; $display("FAIL idle_clear: got %b need 0", bus.lu_clear); end
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b need 0", bus.busy); end
        n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL idle_cmd_ready: got %b need 1", bus.cmd_ready); end
        n_checks++; if (bus.lu_lines_count !== 8'd0) begin n_fail++; $display("FAIL idle_count: got %0d need 0", bus.lu_lines_count); end
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b need 0", bus.busy); end
        n_checks++; if (bus.lu_op_sel !== 8'h00) begin n_fail++; $display("FAIL rst_sel: got %h need 00", bus.lu_op_sel); end
        n_checks++; if (bus.lu_clear !== 1'b0) begin n_fail++; $display("FAIL rst_clear: got %b need 0", bus.lu_clear); end
        n_checks++; if (bus.row_out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid: got %b need 0", bus.row_out_valid); end
        n_checks++; if (bus.row_in_ready !== 1'b0) begin n_fail++; $display("FAIL rst_in_ready: got %b need 0", bus.row_in_ready); end
        n_checks++; if (bus.lu_matrix_a !== 256'd0 || bus.lu_matrix_b !== 256'd0) begin n_fail++; $display("FAIL rst_matrix: got %h need 0", bus.lu_matrix_a | bus.lu_matrix_b); end
        reset = 1'b0;
        @(negedge clk);
        n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_cmd_ready: got %b need 1", bus.cmd_ready); end
        n_checks++; if (bus.err_timeout !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b need 0", bus.err_timeout); end
    endtask

    task automatic test_dsc();
        for (int k = 0; k < 8; k++) begin ra[k] = 32'(k + 1); rb[k] = $urandom; end
        do_op(3'd0, $urandom, 2, 0);
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (got[k] !== 32'((k + 1) % 8 + 1)) begin n_fail++; $display("FAIL dsc_row[%0d]: got %h need %h", k, got[k], (k + 1) % 8 + 1); end
        end
    endtask

    task automatic test_and();
        for (int k = 0; k < 8; k++) begin ra[k] = 32'hFFFF0000; rb[k] = 32'h0F0F0F0F; end
        do_op(3'd5, $urandom, 1, 0);
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (got[k] !== 32'h0F0F0000) begin n_fail++; $display("FAIL and_row[%0d]: got %h need 0f0f0000", k, got[k]); end
        end
    endtask

    task automatic test_backpressure();
        randomize_rows();
        stall = 1;
        do_op(3'd4, 32'h000000FF, 0, 0);
        stall = 0;
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (got[k] !== (ra[k] & 32'hFF)) begin n_fail++; $display("FAIL bp_row[%0d]: got %h need %h", k, got[k], ra[k] & 32'hFF); end
        end
    endtask

    task automatic test_timeout();
        randomize_rows();
        do_op(3'd1, $urandom, -1, 0);
        randomize_rows();
        do_op(3'd6, $urandom, 3, 0);
    endtask

    task automatic test_reset_mid_load();
        logic [31:0] c;
        bus.cmd_valid = 1'b1; bus.cmd_op = 3'd2; bus.cmd_const = $urandom;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.row_in_valid = 1'b1; bus.row_in_data = $urandom;
            @(negedge clk);
        end
        bus.row_in_valid = 1'b0;
        n_checks++; if (bus.lu_lines_count !== 8'd5) begin n_fail++; $display("FAIL mid_count: got %0d need 5", bus.lu_lines_count); end
        #2 reset = 1'b1;
        #1;
        n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %b need 0", bus.busy); end
        n_checks++; if (bus.lu_lines_count !== 8'd0) begin n_fail++; $display("FAIL mid_lines: got %0d need 0", bus.lu_lines_count); end
        n_checks++; if (bus.lu_matrix_a !== 256'd0) begin n_fail++; $display("FAIL mid_a: got %h need 0", bus.lu_matrix_a); end
        n_checks++; if (bus.lu_constant !== 32'd0) begin n_fail++; $display("FAIL mid_const: got %h need 0", bus.lu_constant); end
        n_checks++; if (bus.row_in_ready !== 1'b0) begin n_fail++; $display("FAIL mid_in_ready: got %b need 0", bus.row_in_ready); end
        @(negedge clk);
        reset = 1'b0;
        randomize_rows();
        c = $urandom;
        do_op(3'd6, c, 1, 0);
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (got[k] !== (ra[k] ^ c)) begin n_fail++; $display("FAIL xwc_row[%0d]: got %h need %h", k, got[k], ra[k] ^ c); end
        end
    endtask

    task automatic test_busy_reject();
        randomize_rows();
        next_op = 3'd7; next_const = $urandom;
        hold_cmd = 1;
        do_op(3'd3, $urandom, 1, 0);
        hold_cmd = 0;
        n_checks++; if (bus.cmd_valid !== 1'b1) begin n_fail++; $display("FAIL busy_held: got %b need 1", bus.cmd_valid); end
        randomize_rows();
        do_op(3'd7, next_const, 0, 1);
        for (int k = 0; k < 8; k++) begin
            n_checks++; if (got[k] !== (ra[k] | rb[k])) begin n_fail++; $display("FAIL or_row[%0d]: got %h need %h", k, got[k], ra[k] | rb[k]); end
        end
    endtask

    task automatic test_random_ops();
        for (int i = 0; i < 6; i++) begin
            randomize_rows();
            stall = $urandom_range(0, 1) != 0;
            do_op(3'($urandom_range(0, 7)), $urandom, $urandom_range(0, 5), 0);
        end
        stall = 0;
    endtask

    initial begin
        bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_const = '0;
        bus.row_in_valid = 1'b0; bus.row_in_data = '0; bus.row_out_ready = 1'b0;
        bus.lu_ready = 1'b0; bus.lu_result = '0;
        test_reset();
        test_dsc();
        test_and();
        test_backpressure();
        test_timeout();
        test_reset_mid_load();
        test_busy_reject();
        test_random_ops();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
